// File: rtl/csr_file_pkg.sv
// rtl/csr_file_pkg.sv - machine-mode CSR addresses, op encodings and bit positions
package csr_file_pkg;

    typedef enum logic [1:0] {
        CSR_NOP = 2'd0,
        CSR_RW  = 2'd1,
        CSR_RS  = 2'd2,
        CSR_RC  = 2'd3
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MISA          = 12'h301;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MSTATUS_MPP  = 11;
    localparam int MIP_MSIP     = 3;
    localparam int MIP_MTIP     = 7;
    localparam int MIP_MEIP     = 11;
    localparam int CNT_CY       = 0;
    localparam int CNT_IR       = 2;
    localparam int CNT_LO_W     = 32;

endpackage

// File: rtl/csr_file_if.sv
// rtl/csr_file_if.sv - CSR access bus between the core pipeline and the CSR file
interface csr_file_if #(
    parameter int XLEN = 32
);
    logic            csr_rd;
    logic [1:0]      csr_wr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;

    modport master (
        output csr_rd, csr_wr_op, csr_addr, csr_wdata,
        input  csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_rd, csr_wr_op, csr_addr, csr_wdata,
        output csr_rdata, csr_illegal
    );
endinterface

// File: rtl/csr_counter.sv
// rtl/csr_counter.sv - wide event counter with independent low/high half writes
module csr_counter #(
    parameter int W    = 64,
    parameter int LO_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              wr_lo,
    input  logic              wr_hi,
    input  logic [LO_W-1:0]   wdata_lo,
    input  logic [W-LO_W-1:0] wdata_hi,
    output logic [W-1:0]      value
);

    // A write to either half suppresses the increment so the untouched half holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) value[LO_W-1:0] <= wdata_lo;
            if (wr_hi) value[W-1:LO_W] <= wdata_hi;
        end else if (en) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine-mode CSR file with trap entry/return, interrupts and counters
module csr_file
    import csr_file_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int HART_ID = 0,
    parameter int CNT_W   = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    csr_file_if.slave       bus,
    input  logic            trap_take,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret,
    input  logic            instr_retire,
    input  logic            ext_irq,
    input  logic            timer_irq,
    input  logic            sw_irq,
    output logic            irq_req,
    output logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] mepc_out
);

    localparam int              HI_W     = CNT_W - CNT_LO_W;
    localparam logic [XLEN-1:0] MISA_VAL = (XLEN'(XLEN == 64 ? 2 : 1) << (XLEN - 2)) | XLEN'(1 << 8);
    localparam logic [XLEN-1:0] MIE_MASK = XLEN'(12'h888);
    localparam logic [XLEN-1:0] CNT_MASK = XLEN'(5);

    logic            run_q;
    logic            mie_bit, mpie_bit;
    logic [XLEN-1:0] mie_q, mtvec_q, mcountinhibit_q;
    logic [XLEN-1:0] mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [2:0]      irq_q;
    logic [CNT_W-1:0] mcycle_v, minstret_v;

    csr_op_e         op;
    logic            implemented, illegal, wr_en;
    logic [XLEN-1:0] rvalue, new_val, mstatus_val, mip_val;

    assign op = csr_op_e'(bus.csr_wr_op);

    always_comb begin
        mstatus_val                          = '0;
        mstatus_val[MSTATUS_MIE]             = mie_bit;
        mstatus_val[MSTATUS_MPIE]            = mpie_bit;
        mstatus_val[MSTATUS_MPP+1:MSTATUS_MPP] = 2'b11;
        mip_val                              = '0;
        mip_val[MIP_MEIP]                    = irq_q[2];
        mip_val[MIP_MTIP]                    = irq_q[1];
        mip_val[MIP_MSIP]                    = irq_q[0];
    end

    always_comb begin
        rvalue      = '0;
        implemented = 1'b1;
        case (bus.csr_addr)
            CSR_MSTATUS:       rvalue = mstatus_val;
            CSR_MISA:          rvalue = MISA_VAL;
            CSR_MIE:           rvalue = mie_q;
            CSR_MTVEC:         rvalue = mtvec_q;
            CSR_MCOUNTINHIBIT: rvalue = mcountinhibit_q;
            CSR_MSCRATCH:      rvalue = mscratch_q;
            CSR_MEPC:          rvalue = mepc_q;
            CSR_MCAUSE:        rvalue = mcause_q;
            CSR_MTVAL:         rvalue = mtval_q;
            CSR_MIP:           rvalue = mip_val;
            CSR_MCYCLE:        rvalue = XLEN'(mcycle_v[CNT_LO_W-1:0]);
            CSR_MCYCLEH:       rvalue = XLEN'(mcycle_v[CNT_W-1:CNT_LO_W]);
            CSR_MINSTRET:      rvalue = XLEN'(minstret_v[CNT_LO_W-1:0]);
            CSR_MINSTRETH:     rvalue = XLEN'(minstret_v[CNT_W-1:CNT_LO_W]);
            CSR_MHARTID:       rvalue = XLEN'(HART_ID);
            default:           implemented = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            CSR_RW:  new_val = bus.csr_wdata;
            CSR_RS:  new_val = rvalue | bus.csr_wdata;
            CSR_RC:  new_val = rvalue & ~bus.csr_wdata;
            default: new_val = rvalue;
        endcase
    end

    assign illegal = (!implemented && (bus.csr_rd || op != CSR_NOP)) ||
                     (op != CSR_NOP && bus.csr_addr[11:10] == 2'b11);
    // run_q keeps the first edge after reset release from committing anything.
    assign wr_en   = (op != CSR_NOP) && !illegal && run_q;

    assign bus.csr_illegal = illegal;
    assign bus.csr_rdata   = bus.csr_rd ? rvalue : '0;
    assign irq_req         = mie_bit & |(mie_q & mip_val);
    assign mepc_out        = mepc_q;

    always_comb begin
        trap_vector = {mtvec_q[XLEN-1:2], 2'b00};
        if (mtvec_q[1:0] == 2'b01 && trap_cause[XLEN-1])
            trap_vector = {mtvec_q[XLEN-1:2], 2'b00} + {trap_cause[XLEN-3:0], 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q           <= 1'b0;
            mie_bit         <= 1'b0;
            mpie_bit        <= 1'b0;
            mie_q           <= '0;
            mtvec_q         <= '0;
            mcountinhibit_q <= '0;
            mscratch_q      <= '0;
            mepc_q          <= '0;
            mcause_q        <= '0;
            mtval_q         <= '0;
            irq_q           <= '0;
        end else begin
            run_q <= 1'b1;
            irq_q <= {ext_irq, timer_irq, sw_irq};
            if (run_q) begin
                if (trap_take) begin
                    mepc_q   <= trap_pc & ~XLEN'(3);
                    mcause_q <= trap_cause;
                    mpie_bit <= mie_bit;
                    mie_bit  <= 1'b0;
                end else if (mret) begin
                    mie_bit  <= mpie_bit;
                    mpie_bit <= 1'b1;
                end else if (wr_en && bus.csr_addr == CSR_MSTATUS) begin
                    mie_bit  <= new_val[MSTATUS_MIE];
                    mpie_bit <= new_val[MSTATUS_MPIE];
                end
                if (!trap_take && wr_en && bus.csr_addr == CSR_MEPC)   mepc_q   <= new_val;
                if (!trap_take && wr_en && bus.csr_addr == CSR_MCAUSE) mcause_q <= new_val;
                if (wr_en && bus.csr_addr == CSR_MIE)           mie_q           <= new_val & MIE_MASK;
                if (wr_en && bus.csr_addr == CSR_MCOUNTINHIBIT) mcountinhibit_q <= new_val & CNT_MASK;
                if (wr_en && bus.csr_addr == CSR_MSCRATCH)      mscratch_q      <= new_val;
                if (wr_en && bus.csr_addr == CSR_MTVAL)         mtval_q         <= new_val;
                // Only direct mode (0) and vectored mode (1) exist; bit 1 never stores.
                if (wr_en && bus.csr_addr == CSR_MTVEC)
                    mtvec_q <= {new_val[XLEN-1:2], 1'b0, new_val[1:0] == 2'b01};
            end
        end
    end

    csr_counter #(.W(CNT_W), .LO_W(CNT_LO_W)) u_mcycle (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (run_q && !mcountinhibit_q[CNT_CY]),
        .wr_lo    (wr_en && bus.csr_addr == CSR_MCYCLE),
        .wr_hi    (wr_en && bus.csr_addr == CSR_MCYCLEH),
        .wdata_lo (new_val[CNT_LO_W-1:0]),
        .wdata_hi (new_val[HI_W-1:0]),
        .value    (mcycle_v)
    );

    csr_counter #(.W(CNT_W), .LO_W(CNT_LO_W)) u_minstret (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (run_q && instr_retire && !mcountinhibit_q[CNT_IR]),
        .wr_lo    (wr_en && bus.csr_addr == CSR_MINSTRET),
        .wr_hi    (wr_en && bus.csr_addr == CSR_MINSTRETH),
        .wdata_lo (new_val[CNT_LO_W-1:0]),
        .wdata_hi (new_val[HI_W-1:0]),
        .value    (minstret_v)
    );

endmodule

// File: tb/tb_csr_file.sv
// tb/tb_csr_file.sv - scoreboard-driven bench for the machine-mode CSR file
module tb_csr_file;
    import csr_file_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trap_take, mret, instr_retire;
    logic [31:0] trap_cause, trap_pc;
    logic        ext_irq, timer_irq, sw_irq;
    logic        irq_req;
    logic [31:0] trap_vector, mepc_out;

    int          checks = 0;
    int          errors = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    csr_file_if #(.XLEN(32)) bus ();

    csr_file #(.XLEN(32), .HART_ID(0), .CNT_W(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .trap_take    (trap_take),
        .trap_cause   (trap_cause),
        .trap_pc      (trap_pc),
        .mret         (mret),
        .instr_retire (instr_retire),
        .ext_irq      (ext_irq),
        .timer_irq    (timer_irq),
        .sw_irq       (sw_irq),
        .irq_req      (irq_req),
        .trap_vector  (trap_vector),
        .mepc_out     (mepc_out)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check_val("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check_val(t, obs, e);
        end
    endtask

    task automatic csr_read(input logic [11:0] addr, input string tag, input logic [31:0] exp);
        @(negedge clk);
        bus.csr_rd   = 1'b1;
        bus.csr_addr = addr;
        sb_push(tag, exp);
        #1;
        sb_pop(bus.csr_rdata);
        bus.csr_rd = 1'b0;
    endtask

    task automatic csr_write(input csr_op_e op, input logic [11:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.csr_wr_op = op;
        bus.csr_addr  = addr;
        bus.csr_wdata = data;
        @(posedge clk);
        #1;
        bus.csr_wr_op = CSR_NOP;
    endtask

    initial begin
        bus.csr_rd = 1'b0; bus.csr_wr_op = CSR_NOP; bus.csr_addr = '0; bus.csr_wdata = '0;
        trap_take = 1'b0; mret = 1'b0; instr_retire = 1'b0;
        trap_cause = '0; trap_pc = '0;
        ext_irq = 1'b0; timer_irq = 1'b0; sw_irq = 1'b0;

        #2;
        sb_push("reset_irq_req", 32'd0);     sb_pop({31'd0, irq_req});
        sb_push("reset_mepc_out", 32'd0);    sb_pop(mepc_out);
        sb_push("reset_trap_vector", 32'd0); sb_pop(trap_vector);

        // Write presented across reset release must be dropped.
        @(negedge clk);
        bus.csr_wr_op = CSR_RW; bus.csr_addr = CSR_MSCRATCH; bus.csr_wdata = 32'h1234;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.csr_wr_op = CSR_NOP;
        csr_read(CSR_MSCRATCH, "release_write_dropped", 32'd0);
        csr_read(CSR_MSTATUS, "mstatus_reset", 32'h0000_1800);

        csr_write(CSR_RW, CSR_MSCRATCH, 32'hA5A5_0000);
        csr_write(CSR_RS, CSR_MSCRATCH, 32'h0000_00FF);
        csr_write(CSR_RC, CSR_MSCRATCH, 32'h0000_000F);
        csr_read(CSR_MSCRATCH, "mscratch_rw_rs_rc", 32'hA5A5_00F0);

        csr_write(CSR_RW, CSR_MTVEC, 32'h0000_1003);
        csr_read(CSR_MTVEC, "mtvec_mode3_to_0", 32'h0000_1000);
        csr_write(CSR_RW, CSR_MTVEC, 32'h0000_1001);
        csr_read(CSR_MTVEC, "mtvec_vectored", 32'h0000_1001);
        @(negedge clk);
        trap_cause = 32'h8000_0007;
        sb_push("trap_vector_irq7", 32'h0000_101C); #1; sb_pop(trap_vector);
        trap_cause = 32'h0000_0002;
        sb_push("trap_vector_exc2", 32'h0000_1000); #1; sb_pop(trap_vector);

        csr_write(CSR_RS, CSR_MSTATUS, 32'h0000_0008);
        csr_write(CSR_RW, CSR_MIE, 32'h0000_0080);
        csr_read(CSR_MSTATUS, "mstatus_mie_set", 32'h0000_1808);
        @(negedge clk);
        timer_irq = 1'b1;
        sb_push("irq_req_before_sync", 32'd0);
        sb_push("irq_req_after_sync", 32'd1);
        #1; sb_pop({31'd0, irq_req});
        @(posedge clk); #1; sb_pop({31'd0, irq_req});
        csr_read(CSR_MIP, "mip_mtip", 32'h0000_0080);

        // Trap and a competing mepc write in the same cycle.
        @(negedge clk);
        trap_take = 1'b1; trap_pc = 32'h0000_0103; trap_cause = 32'h8000_0007;
        bus.csr_wr_op = CSR_RW; bus.csr_addr = CSR_MEPC; bus.csr_wdata = 32'hDEAD_BEE0;
        sb_push("mepc_out_after_trap", 32'h0000_0100);
        sb_push("irq_req_after_trap", 32'd0);
        @(posedge clk); #1;
        trap_take = 1'b0; bus.csr_wr_op = CSR_NOP;
        sb_pop(mepc_out);
        sb_pop({31'd0, irq_req});
        csr_read(CSR_MEPC, "mepc_trap_wins", 32'h0000_0100);
        csr_read(CSR_MCAUSE, "mcause_trap", 32'h8000_0007);
        csr_read(CSR_MSTATUS, "mstatus_after_trap", 32'h0000_1880);
        @(negedge clk); mret = 1'b1;
        @(posedge clk); #1; mret = 1'b0;
        csr_read(CSR_MSTATUS, "mstatus_after_mret", 32'h0000_1888);

        // Trap concurrent with a write to an unrelated register.
        @(negedge clk);
        trap_take = 1'b1; trap_pc = 32'h0000_0206; trap_cause = 32'h0000_0002;
        bus.csr_wr_op = CSR_RW; bus.csr_addr = CSR_MSCRATCH; bus.csr_wdata = 32'h0000_0077;
        @(posedge clk); #1;
        trap_take = 1'b0; bus.csr_wr_op = CSR_NOP;
        csr_read(CSR_MSCRATCH, "mscratch_write_beside_trap", 32'h0000_0077);
        csr_read(CSR_MEPC, "mepc_second_trap", 32'h0000_0204);
        @(negedge clk); mret = 1'b1;
        @(posedge clk); #1; mret = 1'b0;

        @(negedge clk);
        bus.csr_wr_op = CSR_RW; bus.csr_addr = CSR_MHARTID; bus.csr_wdata = 32'h5;
        sb_push("illegal_mhartid_write", 32'd1); #1; sb_pop({31'd0, bus.csr_illegal});
        @(posedge clk); #1; bus.csr_wr_op = CSR_NOP;
        csr_read(CSR_MHARTID, "mhartid_value", 32'd0);
        @(negedge clk);
        bus.csr_wr_op = CSR_RW; bus.csr_addr = 12'h7C0; bus.csr_wdata = 32'hFFFF_FFFF;
        sb_push("illegal_unimpl_write", 32'd1); #1; sb_pop({31'd0, bus.csr_illegal});
        @(posedge clk); #1; bus.csr_wr_op = CSR_NOP;
        csr_read(CSR_MSCRATCH, "mscratch_untouched", 32'h0000_0077);
        @(negedge clk);
        bus.csr_rd = 1'b1; bus.csr_addr = 12'h7C0;
        sb_push("illegal_unimpl_read", 32'd1); #1; sb_pop({31'd0, bus.csr_illegal});
        bus.csr_addr = CSR_MSCRATCH;
        sb_push("legal_read", 32'd0); #1; sb_pop({31'd0, bus.csr_illegal});
        bus.csr_rd = 1'b0;

        csr_write(CSR_RW, CSR_MCOUNTINHIBIT, 32'h1);
        csr_write(CSR_RW, CSR_MCYCLE, 32'hFFFF_FFFF);
        csr_write(CSR_RW, CSR_MCYCLEH, 32'h0);
        csr_read(CSR_MCYCLE, "mcycle_frozen", 32'hFFFF_FFFF);
        csr_write(CSR_RC, CSR_MCOUNTINHIBIT, 32'h1);
        csr_read(CSR_MCYCLE, "mcycle_before_wrap", 32'hFFFF_FFFF);
        csr_read(CSR_MCYCLE, "mcycle_wrapped", 32'h0);
        csr_read(CSR_MCYCLEH, "mcycleh_carry", 32'h1);
        csr_write(CSR_RW, CSR_MCYCLE, 32'h10);
        csr_read(CSR_MCYCLE, "mcycle_write_override", 32'h10);
        csr_read(CSR_MCYCLEH, "mcycleh_holds", 32'h1);

        csr_write(CSR_RW, CSR_MINSTRET, 32'h0);
        @(negedge clk); instr_retire = 1'b1;
        repeat (3) @(posedge clk);
        #1; instr_retire = 1'b0;
        csr_read(CSR_MINSTRET, "minstret_count", 32'h3);

        csr_write(CSR_RW, CSR_MCOUNTINHIBIT, 32'h5);
        csr_write(CSR_RW, CSR_MCYCLE, 32'h55);
        csr_write(CSR_RW, CSR_MCYCLEH, 32'h7);
        @(negedge clk); instr_retire = 1'b1;
        repeat (5) @(posedge clk);
        #1; instr_retire = 1'b0;
        csr_read(CSR_MCYCLE, "mcycle_inhibited", 32'h55);
        csr_read(CSR_MCYCLEH, "mcycleh_inhibited", 32'h7);
        csr_read(CSR_MINSTRET, "minstret_inhibited", 32'h3);
        csr_write(CSR_RW, CSR_MCOUNTINHIBIT, 32'h0);

        // Asynchronous reset in the middle of a clock phase.
        @(negedge clk);
        sb_push("irq_req_before_reset", 32'd1); #1; sb_pop({31'd0, irq_req});
        #1;
        rst_n = 1'b0;
        bus.csr_rd = 1'b1; bus.csr_addr = CSR_MCYCLE;
        sb_push("reset_mcycle", 32'd0);
        sb_push("reset_irq_req_mid", 32'd0);
        sb_push("reset_mepc_out_mid", 32'd0);
        sb_push("reset_trap_vector_mid", 32'd0);
        #1;
        sb_pop(bus.csr_rdata);
        sb_pop({31'd0, irq_req});
        sb_pop(mepc_out);
        sb_pop(trap_vector);
        bus.csr_addr = CSR_MSTATUS;
        sb_push("reset_mstatus_mid", 32'h0000_1800); #1; sb_pop(bus.csr_rdata);
        bus.csr_addr = CSR_MSCRATCH;
        sb_push("reset_mscratch_mid", 32'd0); #1; sb_pop(bus.csr_rdata);
        bus.csr_rd = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);

        if (exp_q.size() != 0) check_val("scoreboard_leftover", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter HART_ID, default 0, value returned by mhartid.
REQ-003 SHALL have parameter CNT_W, default 64, mcycle/minstret width (range 33..64).
REQ-004 SHALL have ports clk  in  1  clock (one clock, rising edge); rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports csr_rd  in  1  read strobe; csr_wr_op  in  2  op (NOP=0, RW=1, RS=2, RC=3); csr_addr  in  12  CSR address; csr_wdata  in  XLEN  write operand.
REQ-006 SHALL have ports csr_rdata  out  XLEN  read data; csr_illegal  out  1  access fault.
REQ-007 SHALL have ports trap_take  in  1; trap_cause  in  XLEN; trap_pc  in  XLEN; mret  in  1; instr_retire  in  1.
REQ-008 SHALL have ports ext_irq, timer_irq, sw_irq  in  1 each; irq_req  out  1; trap_vector  out  XLEN; mepc_out  out  XLEN.

Function
REQ-009 SHALL implement mstatus (MIE bit 3, MPIE bit 7, MPP bits 12:11 read 2'b11), misa, mie, mip, mtvec, mscratch, mepc, mcause, mtval, mcountinhibit, mcycle/mcycleh, minstret/minstreth, mhartid.
REQ-010 SHALL return csr_rdata combinationally from csr_addr; 0 when csr_rd low.
REQ-011 SHALL write, for a non-NOP op, RW: wdata; RS: old | wdata; RC: old & ~wdata; new value visible on the next cycle.
REQ-012 SHALL assert csr_illegal combinationally for an unimplemented address with csr_rd or non-NOP op, or for a non-NOP op to a read-only address (top two address bits 2'b11); no state change then.
REQ-013 SHALL treat mip as read-only: MEIP/MTIP/MSIP (bits 11/7/3) equal registered copies of ext_irq/timer_irq/sw_irq, one-cycle latency.
REQ-014 SHALL drive irq_req = mstatus.MIE & |(mie & mip).
REQ-015 SHALL, on trap_take: mepc<=trap_pc with bits 1:0 cleared, mcause<=trap_cause, MPIE<=MIE, MIE<=0.
REQ-016 SHALL, on mret: MIE<=MPIE, MPIE<=1.
REQ-017 SHALL prioritise trap_take over mret over CSR write for every register those events update; a lower-priority write to another register proceeds.
REQ-018 SHALL drive trap_vector = {mtvec[XLEN-1:2],2'b00}; if mtvec[1:0]==1 and trap_cause MSB set, add 4*trap_cause[XLEN-2:0] (modulo 2^XLEN).
REQ-019 SHALL hardwire mtvec[1] to 0; writing mode 2 or 3 stores mode 0.
REQ-020 SHALL increment mcycle every cycle unless mcountinhibit[0]; minstret on instr_retire unless mcountinhibit[2]; wrap to 0 at 2^CNT_W.
REQ-021 SHALL make a CSR write to a counter half override that cycle's increment; the other half holds.
REQ-022 SHALL read bits above CNT_W in mcycleh/minstreth as 0 and ignore writes to them.
REQ-023 SHALL drive mepc_out = mepc.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear all registers and mip copies, force MIE=0, MPIE=0, mtvec=0; outputs then: irq_req=0, mepc_out=0, trap_vector=0.
REQ-025 SHALL discard any write, trap or increment in the cycle rst_n is released.

Structure
REQ-026 SHALL place CSR address constants, op encodings and bit-position constants in the shared core package.
REQ-027 SHALL instantiate sub-module csr_counter (CNT_W counter, enable, split lo/hi write) twice.

Verification
REQ-028 SHALL cover: RW 0xA5A5_0000 to mscratch, RS 0x0000_00FF, RC 0x0000_000F -> reads 0xA5A5_00F0.
REQ-029 SHALL cover: MIE=1, mie=0x80, timer_irq=1 -> irq_req=1 one cycle later; trap_take, trap_pc=0x103, cause=0x8000_0007 -> mepc=0x100, MIE=0, MPIE=1; mret -> MIE=1.
REQ-030 SHALL cover: mtvec write 0x0000_1001, cause 0x8000_0007 -> trap_vector=0x0000_101C; cause 2 -> 0x0000_1000.
REQ-031 SHALL cover: mcycle=0xFFFF_FFFF, mcycleh=0 -> next cycle mcycle=0, mcycleh=1; mcountinhibit[0]=1 freezes both.
REQ-032 SHALL cover: write to mhartid (0xF14) and to 0x7C0 -> csr_illegal=1, no state change; trap_take and RW to mepc in same cycle -> trap value wins.
REQ-033 SHALL cover: rst_n asserted mid-count -> all state 0 immediately, irq_req=0.
